// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the piso serializer.
// The Parity state is only reachable when PISO_PARITY_EN is defined.
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } t_state;

    function automatic int cnt_width(input int bits);
        return (bits > 1) ? $clog2(bits) : 1;
    endfunction

endpackage

// File: rtl/piso_parity_gen.sv
// Even-parity (XOR reduction) of a data word; only built when PISO_PARITY_EN is defined.
`ifdef PISO_PARITY_EN
module parity_gen #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] in_data,
    output logic            out_parity
);

    assign out_parity = ^in_data;

endmodule
`endif

// File: rtl/piso.sv
// Parallel-in serial-out shifter with load/shift handshake and a registered done pulse.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso
    import piso_pkg::*;
#(
    parameter int BITS        = 8,
    parameter bit SHIFT_RIGHT = 1'b1
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic [BITS-1:0] in_parallel,
    input  logic            in_load,
    input  logic            in_shift_en,
    output logic            out_ready,
    output logic            out_serial,
    output logic            out_bit_valid,
    output logic            out_done
);

    localparam int            CW   = cnt_width(BITS);
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    t_state          state_q, state_d;
    logic [BITS-1:0] sreg_q, sreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;

`ifdef PISO_PARITY_EN
    logic parity_q, parity_d, parity_w;

    parity_gen #(.BITS(BITS)) u_parity_gen (
        .in_data    (in_parallel),
        .out_parity (parity_w)
    );
`endif

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q  <= ST_IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_load) begin
                    sreg_d   = in_parallel;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT;
`ifdef PISO_PARITY_EN
                    parity_d = parity_w;
`endif
                end
            end
            ST_SHIFT: begin
                if (in_shift_en) begin
                    sreg_d = SHIFT_RIGHT ? (sreg_q >> 1) : (sreg_q << 1);
                    // Counter stops at LAST; the state change ends the word.
                    if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                if (in_shift_en) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_serial = 1'b0;
        case (state_q)
            ST_SHIFT:  out_serial = SHIFT_RIGHT ? sreg_q[0] : sreg_q[BITS-1];
`ifdef PISO_PARITY_EN
            ST_PARITY: out_serial = parity_q;
`endif
            default:   out_serial = 1'b0;
        endcase
    end

    assign out_ready     = (state_q == ST_IDLE);
    assign out_bit_valid = (state_q != ST_IDLE);
    assign out_done      = done_q;

endmodule

// File: doc/piso.md
PISO -- requirements
Module: piso

Interface
REQ-001 Parameter BITS, default 8, data word width in bits (>= 2).
REQ-002 Parameter SHIFT_RIGHT, default 1'b1, bit order: 1 = LSB first, 0 = MSB first. Pairs with sipo of the same setting.
REQ-003 in_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 in_rst  input  1  reset; synchronous, active-high.
REQ-005 in_parallel  input  BITS  word to transmit; sampled only on an accepted load.
REQ-006 in_load  input  1  load request; accepted only when out_ready=1.
REQ-007 in_shift_en  input  1  bit-advance enable; the current bit is consumed on an edge with in_shift_en=1.
REQ-008 out_ready  output  1  high in Idle: a load is accepted this cycle.
REQ-009 out_serial  output  1  current serial bit; 0 when no bit is driven.
REQ-010 out_bit_valid  output  1  high while out_serial carries a data or parity bit.
REQ-011 out_done  output  1  one-cycle pulse after the final bit is consumed.

Function
REQ-012 States: Idle, Shift, Parity (macro only), held in a registered state variable.
REQ-013 Idle: out_ready=1, out_serial=0, out_bit_valid=0.
- in_load=1 at an edge: latch in_parallel into the shift register, clear the bit counter, go to Shift.
REQ-014 Load latency: the first bit appears on out_serial in the cycle after load acceptance.
REQ-015 Shift: out_bit_valid=1, out_ready=0.
- out_serial = register LSB if SHIFT_RIGHT=1, else MSB.
REQ-016 Shift, edge with in_shift_en=1: shift the register one place toward the output end, zero-fill, increment the counter.
REQ-017 Shift, in_shift_en=0: register, counter and out_serial hold for any number of cycles.
REQ-018 Counter width is $clog2(BITS); no wrap. When the counter = BITS-1 and in_shift_en=1: go to Parity if enabled, else to Idle.
REQ-019 out_done is registered and asserted in the first cycle after leaving the last bit state; it is never asserted otherwise.
REQ-020 in_load in any state other than Idle is ignored; the word in transmission is never corrupted.
REQ-021 Back-to-back: a load accepted in the Idle cycle where out_done=1 is legal and starts the next word.
REQ-022 A word takes exactly BITS (+1 with parity) in_shift_en edges; with in_shift_en tied high, Idle-to-Idle is BITS+1 (+1) cycles.

Reset
REQ-023 in_rst=1 at an edge forces Idle, clears the shift register and counter, and sets out_serial=0, out_bit_valid=0, out_done=0, out_ready=1 on the next cycle.
REQ-024 Reset mid-word aborts the transfer without an out_done pulse; in_rst has priority over in_load and in_shift_en.

Configuration
REQ-025 Macro PISO_PARITY_EN, when defined:
- the even-parity bit (XOR of the latched word, computed at load) is sent in the Parity state after the data;
- Parity state: out_bit_valid=1; exit on in_shift_en=1 to Idle with the out_done pulse.
REQ-026 Without PISO_PARITY_EN: no Parity state, no parity register; the word is BITS bits long.

Structure
REQ-027 Package piso_pkg holds the t_state enum (Idle, Shift, Parity) and the bit-counter width function/constant.
REQ-028 Sub-module parity_gen (parameter BITS, in_data to out_parity XOR reduction) is instantiated only under PISO_PARITY_EN.
REQ-029 Shift register, counter and FSM live in piso; all outputs are driven from registers or state decode, never from input-to-output paths.

Verification
REQ-030 Load 0x49, SHIFT_RIGHT=1, in_shift_en high -> out_serial 1,0,0,1,0,0,1,0 over 8 cycles, then out_done pulses once; a looped-back sipo reads 0x49.
REQ-031 Load 0x49, SHIFT_RIGHT=0 -> out_serial 0,1,0,0,1,0,0,1.
REQ-032 Load 0xA5 with in_shift_en toggling 1,0,1,0 -> each bit held two cycles, done after 16 cycles; in_load=1 with 0xFF mid-word has no effect.
REQ-033 in_rst after 3 bits of 0xF0 -> next cycle out_ready=1, out_serial=0, no out_done; a fresh load of 0x0F then transmits correctly.
REQ-034 PISO_PARITY_EN, load 0x07 -> 8 data bits, then parity bit 1, then out_done; load 0x03 -> parity bit 0.
REQ-035 Back-to-back 0x12 then 0x34 loaded on the out_done cycle -> 16 contiguous bits with one idle cycle between words, two out_done pulses.
